// File: rtl/slc3_mem_ctrl.sv
// slc3_mem_ctrl: Req/Ack memory access sequencer for the SLC-3 with programmable SRAM wait states.
// Define SLC3_MMIO_EN to map MMIO_ADDR onto the board switches (read) and hex displays (write).
module slc3_mem_ctrl #(
  parameter int                DATA_W      = 16,
  parameter int                ADDR_W      = 16,
  parameter int                WAIT_STATES = 2,
  parameter int                NUM_HEX     = 4,
  parameter int                SW_W        = 10,
  parameter logic [ADDR_W-1:0] MMIO_ADDR   = '1
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Req,
  input  logic                 Wr,
  input  logic [ADDR_W-1:0]    Addr,
  input  logic [DATA_W-1:0]    Wdata,
  output logic [DATA_W-1:0]    Rdata,
  output logic                 Ack,
  output logic                 Busy,
  output logic [ADDR_W-1:0]    Sram_Addr,
  input  logic [DATA_W-1:0]    Sram_Din,
  output logic [DATA_W-1:0]    Sram_Dout,
  output logic                 OE_n,
  output logic                 WE_n,
  input  logic [SW_W-1:0]      Switches,
  output logic [4*NUM_HEX-1:0] Hex_Data
);

  localparam int         HEX_W    = 4 * NUM_HEX;
  localparam logic [3:0] CNT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_WAIT, S_DONE} state_t;

  state_t            state, next_state;
  logic [3:0]        wait_cnt;
  logic              wr_q;
  logic              sram_sel;
  logic [DATA_W-1:0] rd_src;
  logic              start;
  logic              finish;

  assign start  = (state == S_IDLE) && Req;
  // DONE always falls back to IDLE, so this is high only on the edge entering DONE
  assign finish = (next_state == S_DONE);
  assign Busy   = (state != S_IDLE);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (Req) next_state = S_SETUP;
      S_SETUP: next_state = (WAIT_STATES == 0) ? S_DONE : S_WAIT;
      S_WAIT:  if (wait_cnt == 4'd0) next_state = S_DONE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Strobes are registered so they assert for all of SETUP and WAIT and drop on entering DONE
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wait_cnt  <= '0;
      wr_q      <= 1'b0;
      Sram_Addr <= '0;
      Sram_Dout <= '0;
      OE_n      <= 1'b1;
      WE_n      <= 1'b1;
      Ack       <= 1'b0;
      Rdata     <= '0;
    end else begin
      Ack <= finish;
      if (start) begin
        wr_q      <= Wr;
        Sram_Addr <= Addr;
        if (Wr) Sram_Dout <= Wdata;
        OE_n      <= Wr | ~sram_sel;
        WE_n      <= ~Wr | ~sram_sel;
        wait_cnt  <= CNT_LOAD;
      end
      if (state == S_WAIT && wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
      if (finish) begin
        OE_n <= 1'b1;
        WE_n <= 1'b1;
        if (!wr_q) Rdata <= rd_src;
      end
    end
  end

`ifdef SLC3_MMIO_EN
  localparam int EXT_W = (HEX_W > DATA_W) ? HEX_W : DATA_W;

  logic io_q;

  assign sram_sel = (Addr != MMIO_ADDR);
  assign rd_src   = io_q ? DATA_W'(Switches) : Sram_Din;

  // The I/O write data rides in Sram_Dout; the strobes are simply never asserted for it
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      io_q     <= 1'b0;
      Hex_Data <= '0;
    end else begin
      if (start) io_q <= ~sram_sel;
      if (finish && wr_q && io_q) Hex_Data <= HEX_W'(EXT_W'(Sram_Dout));
    end
  end
`else
  logic unused_io;

  assign sram_sel  = 1'b1;
  assign rd_src    = Sram_Din;
  assign Hex_Data  = '0;
  assign unused_io = ^{Switches, MMIO_ADDR};
`endif

endmodule

// File: tb/tb_slc3_mem_ctrl.sv
// tb_slc3_mem_ctrl: directed checks of slc3_mem_ctrl with a WAIT_STATES=2 instance on a small
// SRAM model and a WAIT_STATES=0 instance for the zero-wait path.
`timescale 1ns/1ps
module tb_slc3_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req, wr;
  logic [15:0] addr, wdata, rdata, sram_addr, sram_din, sram_dout, hex_data;
  logic        ack, busy, oe_n, we_n;
  logic [9:0]  switches;

  logic        req0, wr0;
  logic [15:0] addr0, wdata0, rdata0, sram_addr0, sram_din0, sram_dout0, hex_data0;
  logic        ack0, busy0, oe_n0, we_n0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  slc3_mem_ctrl #(.WAIT_STATES(2)) dut (
    .Clk(clk), .Reset(rst), .Req(req), .Wr(wr), .Addr(addr), .Wdata(wdata),
    .Rdata(rdata), .Ack(ack), .Busy(busy), .Sram_Addr(sram_addr), .Sram_Din(sram_din),
    .Sram_Dout(sram_dout), .OE_n(oe_n), .WE_n(we_n), .Switches(switches), .Hex_Data(hex_data)
  );

  slc3_mem_ctrl #(.WAIT_STATES(0)) dut0 (
    .Clk(clk), .Reset(rst), .Req(req0), .Wr(wr0), .Addr(addr0), .Wdata(wdata0),
    .Rdata(rdata0), .Ack(ack0), .Busy(busy0), .Sram_Addr(sram_addr0), .Sram_Din(sram_din0),
    .Sram_Dout(sram_dout0), .OE_n(oe_n0), .WE_n(we_n0), .Switches(switches), .Hex_Data(hex_data0)
  );

  // Unwritten SRAM words read back a pattern derived from the address; 0x0030 holds 0x1234
  logic [15:0] mem [256];
  logic        written [256];

  always @(posedge clk) begin
    if (!we_n) begin
      mem[sram_addr[7:0]]     <= sram_dout;
      written[sram_addr[7:0]] <= 1'b1;
    end
  end

  assign sram_din  = (written[sram_addr[7:0]] === 1'b1) ? mem[sram_addr[7:0]] :
                     (sram_addr == 16'h0030) ? 16'h1234 : {sram_addr[7:0], ~sram_addr[7:0]};
  assign sram_din0 = sram_addr0 ^ 16'hA5A5;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs [8];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // One full access; reports Ack latency in edges after the sampling edge, strobe-low cycle
  // counts, overlap count, and Rdata/Sram_Dout seen in the Ack cycle. Returns with the FSM idle.
  task automatic applyStimulus(input logic wr_i, input logic [15:0] addr_i, input logic [15:0] wdata_i,
                               output int lat, output int oe_c, output int we_c, output int ovl,
                               output logic [15:0] rd, output logic [15:0] dout);
    lat = -1; oe_c = 0; we_c = 0; ovl = 0; rd = 16'h0; dout = 16'h0;
    @(negedge clk);
    req = 1'b1; wr = wr_i; addr = addr_i; wdata = wdata_i;
    @(posedge clk); #1;
    req = 1'b0; addr = 16'h0BAD; wdata = 16'h5555; wr = ~wr_i;
    for (int i = 0; i <= 20; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      if (!oe_n) oe_c++;
      if (!we_n) we_c++;
      if (!oe_n && !we_n) ovl++;
      if (ack) begin
        lat  = i;
        rd   = rdata;
        dout = sram_dout;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          lat, oe_c, we_c, ovl, n_ack, extra;
    int          ack_edge [4];
    logic [15:0] rd, dout;

    vecs[0] = '{1'b0, 16'h0030, 16'h0000, 16'h1234};
    vecs[1] = '{1'b1, 16'h0031, 16'hBEEF, 16'h0000};
    vecs[2] = '{1'b0, 16'h0031, 16'h0000, 16'hBEEF};
    vecs[3] = '{1'b0, 16'h0042, 16'h0000, 16'h42BD};
    vecs[4] = '{1'b1, 16'h0042, 16'h0000, 16'h0000};
    vecs[5] = '{1'b0, 16'h0042, 16'h0000, 16'h0000};
    vecs[6] = '{1'b1, 16'h00A7, 16'h5A3C, 16'h0000};
    vecs[7] = '{1'b0, 16'h00A7, 16'h0000, 16'h5A3C};

    req = 0; wr = 0; addr = 0; wdata = 0; switches = 10'h2A5;
    req0 = 0; wr0 = 0; addr0 = 0; wdata0 = 0;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1;
    checkOutput("reset ack", ack, 1'b0);
    checkOutput("reset busy", busy, 1'b0);
    checkOutput("reset oe_n", oe_n, 1'b1);
    checkOutput("reset we_n", we_n, 1'b1);
    checkOutput("reset rdata", rdata, 16'h0);
    checkOutput("reset sram_addr", sram_addr, 16'h0);
    checkOutput("reset sram_dout", sram_dout, 16'h0);
    checkOutput("reset hex_data", hex_data, 16'h0);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].wr, vecs[i].addr, vecs[i].wdata, lat, oe_c, we_c, ovl, rd, dout);
      checkOutput($sformatf("vec%0d latency", i), lat, 3);
      checkOutput($sformatf("vec%0d oe_n low cycles", i), oe_c, vecs[i].wr ? 0 : 3);
      checkOutput($sformatf("vec%0d we_n low cycles", i), we_c, vecs[i].wr ? 3 : 0);
      checkOutput($sformatf("vec%0d strobe overlap", i), ovl, 0);
      if (vecs[i].wr) checkOutput($sformatf("vec%0d dout held in ack", i), dout, vecs[i].wdata);
      else            checkOutput($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
      checkOutput($sformatf("vec%0d idle after", i), busy, 1'b0);
    end

    // Req held high across three reads, dropped in the third Ack cycle
    @(negedge clk);
    req = 1'b1; wr = 1'b0; addr = 16'h0030;
    n_ack = 0;
    for (int e = 0; e < 25; e++) begin
      @(posedge clk); #1;
      if (ack) begin
        if (n_ack < 4) ack_edge[n_ack] = e;
        n_ack++;
        if (n_ack == 3) req = 1'b0;
      end
    end
    checkOutput("held req ack count", n_ack, 3);
    checkOutput("held req ack1 edge", ack_edge[0], 3);
    checkOutput("held req ack2 edge", ack_edge[1], 8);
    checkOutput("held req ack3 edge", ack_edge[2], 13);
    checkOutput("held req rdata", rdata, 16'h1234);

    // Req toggled while busy must not disturb the read in flight
    @(negedge clk);
    req = 1'b1; wr = 1'b0; addr = 16'h0031;
    @(posedge clk); #1;
    req = 1'b1; wr = 1'b1; addr = 16'h0030; wdata = 16'hDEAD;
    checkOutput("toggle busy", busy, 1'b1);
    @(posedge clk); #1;
    req = 1'b0;
    checkOutput("toggle no ack e1", ack, 1'b0);
    @(posedge clk); #1;
    req = 1'b1;
    checkOutput("toggle no ack e2", ack, 1'b0);
    @(posedge clk); #1;
    req = 1'b0;
    checkOutput("toggle ack e3", ack, 1'b1);
    checkOutput("toggle rdata", rdata, 16'hBEEF);
    extra = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ack) extra++;
    end
    checkOutput("toggle extra acks", extra, 0);
    checkOutput("toggle idle", busy, 1'b0);
    applyStimulus(1'b0, 16'h0030, 16'h0, lat, oe_c, we_c, ovl, rd, dout);
    checkOutput("toggle no stray write", rd, 16'h1234);

    // Reset in the middle of a write's WAIT phase
    @(negedge clk);
    req = 1'b1; wr = 1'b1; addr = 16'h0055; wdata = 16'h1357;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #3;
    checkOutput("pre-reset we_n low", we_n, 1'b0);
    rst = 1'b1;
    #1;
    checkOutput("abort we_n", we_n, 1'b1);
    checkOutput("abort busy", busy, 1'b0);
    checkOutput("abort ack", ack, 1'b0);
    checkOutput("abort rdata", rdata, 16'h0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("post-reset idle", busy, 1'b0);

    // Zero wait-state instance
    @(negedge clk);
    req0 = 1'b1; wr0 = 1'b0; addr0 = 16'h0012;
    @(posedge clk); #1;
    req0 = 1'b0;
    checkOutput("ws0 read oe_n", oe_n0, 1'b0);
    checkOutput("ws0 read ack early", ack0, 1'b0);
    @(posedge clk); #1;
    checkOutput("ws0 read ack", ack0, 1'b1);
    checkOutput("ws0 read rdata", rdata0, 16'hA5B7);
    checkOutput("ws0 read oe_n done", oe_n0, 1'b1);
    @(posedge clk); #1;
    checkOutput("ws0 read idle", busy0, 1'b0);
    @(negedge clk);
    req0 = 1'b1; wr0 = 1'b1; addr0 = 16'h0020; wdata0 = 16'h6789;
    @(posedge clk); #1;
    req0 = 1'b0;
    checkOutput("ws0 write we_n", we_n0, 1'b0);
    checkOutput("ws0 write oe_n", oe_n0, 1'b1);
    @(posedge clk); #1;
    checkOutput("ws0 write ack", ack0, 1'b1);
    checkOutput("ws0 write we_n done", we_n0, 1'b1);
    checkOutput("ws0 write dout held", sram_dout0, 16'h6789);
    @(posedge clk); #1;

`ifdef SLC3_MMIO_EN
    applyStimulus(1'b0, 16'hFFFF, 16'h0, lat, oe_c, we_c, ovl, rd, dout);
    checkOutput("io read latency", lat, 3);
    checkOutput("io read rdata", rd, 16'h02A5);
    checkOutput("io read oe_n never low", oe_c, 0);
    applyStimulus(1'b1, 16'hFFFF, 16'hC0DE, lat, oe_c, we_c, ovl, rd, dout);
    checkOutput("io write latency", lat, 3);
    checkOutput("io write we_n never low", we_c, 0);
    checkOutput("io write hex_data", hex_data, 16'hC0DE);
`else
    applyStimulus(1'b1, 16'hFFFF, 16'h7777, lat, oe_c, we_c, ovl, rd, dout);
    checkOutput("top addr write we_n cycles", we_c, 3);
    checkOutput("top addr hex_data tied", hex_data, 16'h0);
    applyStimulus(1'b0, 16'hFFFF, 16'h0, lat, oe_c, we_c, ovl, rd, dout);
    checkOutput("top addr read oe_n cycles", oe_c, 3);
    checkOutput("top addr read rdata", rd, 16'h7777);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
